// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - game-flow sequencer: title/intro/play/clear/victory/game-over, level number and strobe
module level_sequencer #(
  parameter int MAX_LEVEL    = 8,
  parameter int LIVES        = 3,
  parameter int INTRO_FRAMES = 60,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       enemies_cleared,
  input  logic [3:0] dead_count_1,
  input  logic [3:0] dead_count_2,
  output logic [3:0] level_out,
  output logic       level_change,
  output logic       game_active,
  output logic       freeze,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTRO     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_VICTORY   = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_level;
  logic [3:0] w_level_next;
  logic       r_change;
  logic       w_change_next;
  logic       r_active;
  logic       r_freeze;
  logic [7:0] r_cnt;
  logic       r_entry;
  logic       r_vsync_q;
  logic       r_start_q;

  logic w_tick;
  logic w_press;
  logic w_count_ok;
  logic w_all_dead;

  assign w_tick     = vsync_in & ~r_vsync_q;
  assign w_press    = start_btn & ~r_start_q;
  // Ticks landing on the first cycle of a state are ignored
  assign w_count_ok = w_tick & ~r_entry;
  assign w_all_dead = (dead_count_1 >= 4'(LIVES)) && (dead_count_2 >= 4'(LIVES));

  always_comb begin
    w_next        = r_state;
    w_level_next  = r_level;
    w_change_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_next        = ST_INTRO;
          w_level_next  = 4'd1;
          w_change_next = 1'b1;
        end
      end
      ST_INTRO: begin
        if (w_count_ok && (r_cnt == 8'(INTRO_FRAMES - 1)))
          w_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_all_dead)
          w_next = ST_GAME_OVER;
        else if (enemies_cleared)
          w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (w_count_ok && (r_cnt == 8'(CLEAR_FRAMES - 1))) begin
          if (r_level >= 4'(MAX_LEVEL)) begin
            w_next = ST_VICTORY;
          end else begin
            w_next        = ST_INTRO;
            w_level_next  = r_level + 4'd1;
            w_change_next = 1'b1;
          end
        end
      end
      ST_VICTORY, ST_GAME_OVER: begin
        if (w_press) begin
          w_next        = ST_IDLE;
          w_level_next  = 4'd0;
          w_change_next = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_level   <= 4'd0;
      r_change  <= 1'b0;
      r_active  <= 1'b0;
      r_freeze  <= 1'b1;
      r_cnt     <= 8'd0;
      r_entry   <= 1'b0;
      r_vsync_q <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_level   <= w_level_next;
      r_change  <= w_change_next;
      r_active  <= (w_next == ST_PLAY);
      r_freeze  <= (w_next != ST_PLAY);
      r_entry   <= (w_next != r_state);
      r_vsync_q <= vsync_in;
      r_start_q <= start_btn;
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (w_count_ok && ((r_state == ST_INTRO) || (r_state == ST_CLEAR)))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign level_out    = r_level;
  assign level_change = r_change;
  assign game_active  = r_active;
  assign freeze       = r_freeze;
  assign state_out    = r_state;

endmodule
